rr_mux2_feeder: RTL and testbench
=================================

Name: rr_mux2_feeder

Overview:
- Upstream feeder for the 2-bit 2:1 multiplexer stage. Accepts 2-bit words from two independent source channels (A, B) over valid/ready handshakes.
- Buffers one word per channel and arbitrates round-robin.
- Presents a registered select plus the chosen word on a single valid/ready output.
- `sel` and `out_data` drive the mux select and data path directly; `sel` is stable for the whole time `out_valid` is high.

Parameters:
- DW, 2, data width of each channel and of the output.
- FIRST_B, 0, round-robin priority after reset: 0 means A wins the first tie, 1 means B wins.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- a_data  in  DW  channel A word.
- a_valid  in  1  channel A word present.
- a_ready  out  1  channel A holding register empty.
- b_data  in  DW  channel B word.
- b_valid  in  1  channel B word present.
- b_ready  out  1  channel B holding register empty.
- out_data  out  DW  selected word (registered).
- out_valid  out  1  out_data/sel valid.
- out_ready  in  1  downstream accepts.
- sel  out  1  source of current output: 0 = A, 1 = B (registered).

Behaviour:
- Reset (rst=1 at a rising edge):
  - a_full=0, b_full=0, out_valid=0, out_data=0, sel=0, prio=FIRST_B, FSM=IDLE.
  - Reset overrides all other activity, including in-flight words, which are discarded.
- Input side, per channel X:
  - X_ready = ~X_full (combinational from register; never depends on X_valid).
  - Accept when X_valid & X_ready: holding reg <= X_data, X_full <= 1.
  - X_full clears only when its word moves to the output register.
  - No same-cycle refill, so per-channel throughput is at most 1 word per 2 cycles.
- Output side, FSM states:
  - IDLE: out_valid=0.
  - SERV_A: out_valid=1, sel=0.
  - SERV_B: out_valid=1, sel=1.
- Load condition: `load = ~out_valid | out_ready`.
- On load, pick a source:
  - Only a_full: take A.
  - Only b_full: take B.
  - Both full: take A if prio=0, else B.
  - Neither full: go to IDLE, out_valid<=0.
- Effect of a pick of channel X:
  - out_data <= X word, sel <= X, X_full <= 0, prio <= ~X, FSM <= SERV_X.
- If out_valid & ~out_ready: hold out_data, sel, and the FSM state; holding registers keep filling.
- Latency: word accepted in cycle N appears on out_valid in cycle N+2 when the output is free and it wins arbitration.
- Aggregate throughput: 1 word/cycle with both channels streaming and out_ready=1; output alternates A,B,A,B.
- prio changes only on an actual pick; an idle cycle does not toggle it.
- Simultaneous accept and pick on the same channel cannot occur, because ready is deasserted while full.
- Backpressure: after out_ready=0 for 3+ cycles, both holding registers fill, both readies are low, and no data is lost.

Optional Feature:
- Macro: RR_MUX2_FEEDER_STATS_EN.
- Defined:
  - Adds outputs cnt_a[7:0] and cnt_b[7:0].
  - Each counts words delivered from its channel, incrementing on out_valid & out_ready with sel=0/1 respectively.
  - Counters saturate at 255 and reset to 0 on rst.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Test Plan:
1. Reset, then a single word: rst=1 for 2 cycles, then a_valid=1, a_data=2'b10 for 1 cycle, out_ready=1 → a_ready=0 for 1 cycle; out_valid=1, sel=0, out_data=2'b10 exactly 2 cycles after acceptance; back to IDLE next cycle.
2. Tie on both channels: both channels present in the same cycle (A=2'b01, B=2'b11), FIRST_B=0 → output order A(01), B(11); sel 0 then 1; prio ends at 0.
3. Continuous streaming: both valid continuously with incrementing data, out_ready=1, 20 cycles → strict A,B alternation, no drops or duplicates, out_valid high every cycle after fill.
4. Backpressure: out_ready=0 for 5 cycles with both sources valid → out_data/sel frozen, a_ready=b_ready=0 after fill; on release, remaining words drain in round-robin order.
5. Reset mid-operation: rst during SERV_B with both holding registers full → next cycle out_valid=0, a_ready=b_ready=1, sel=0; the held words never appear.
6. STATS_EN build: 300 A words and 3 B words delivered → cnt_a=255 (saturated), cnt_b=3.

Source files
------------

// File: rtl/rr_mux2_feeder.sv
// Two-channel round-robin feeder for the 2:1 mux stage: one holding register per channel and a registered sel/out_data.
// A word reaches the output two cycles after acceptance. out_ready=0 freezes the output; sources stall once their holding register is full. Optional RR_MUX2_FEEDER_STATS_EN adds delivery counters.
module rr_mux2_feeder #(
    parameter int DW      = 2,
    parameter bit FIRST_B = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] a_data,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [DW-1:0] b_data,
    input  logic          b_valid,
    output logic          b_ready,
    output logic [DW-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
`ifdef RR_MUX2_FEEDER_STATS_EN
    output logic [7:0]    cnt_a,
    output logic [7:0]    cnt_b,
`endif
    output logic          sel
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERV_A = 2'd1,
        SERV_B = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [DW-1:0] a_hold;
    logic [DW-1:0] b_hold;
    logic          a_full;
    logic          b_full;
    logic          prio;
    logic          load;
    logic          pick_a;
    logic          pick_b;

    assign a_ready   = ~a_full;
    assign b_ready   = ~b_full;
    assign out_valid = (state != IDLE);
    assign load      = ~out_valid | out_ready;

    // prio=0 lets A win a tie, prio=1 lets B win
    always_comb begin
        pick_a    = 1'b0;
        pick_b    = 1'b0;
        state_nxt = state;
        if (load) begin
            if (a_full && (!b_full || !prio)) begin
                pick_a = 1'b1;
            end else if (b_full) begin
                pick_b = 1'b1;
            end
            if (pick_a) begin
                state_nxt = SERV_A;
            end else if (pick_b) begin
                state_nxt = SERV_B;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_hold   <= '0;
            b_hold   <= '0;
            a_full   <= 1'b0;
            b_full   <= 1'b0;
            out_data <= '0;
            sel      <= 1'b0;
            prio     <= FIRST_B;
        end else begin
            // ready is low while full, so accept and pick never coincide on one channel
            if (a_valid && a_ready) begin
                a_hold <= a_data;
                a_full <= 1'b1;
            end else if (pick_a) begin
                a_full <= 1'b0;
            end
            if (b_valid && b_ready) begin
                b_hold <= b_data;
                b_full <= 1'b1;
            end else if (pick_b) begin
                b_full <= 1'b0;
            end
            if (pick_a) begin
                out_data <= a_hold;
                sel      <= 1'b0;
                prio     <= 1'b1;
            end else if (pick_b) begin
                out_data <= b_hold;
                sel      <= 1'b1;
                prio     <= 1'b0;
            end
        end
    end

`ifdef RR_MUX2_FEEDER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a <= 8'd0;
            cnt_b <= 8'd0;
        end else if (out_valid && out_ready) begin
            if (!sel && cnt_a != 8'hFF) begin
                cnt_a <= cnt_a + 8'd1;
            end
            if (sel && cnt_b != 8'hFF) begin
                cnt_b <= cnt_b + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rr_mux2_feeder.sv
// Bench for rr_mux2_feeder: per-cycle vector table plus a scoreboard of expected {sel, data} deliveries.
module tb_rr_mux2_feeder;
    localparam int DW = 2;

    logic          clk;
    logic          rst;
    logic [DW-1:0] a_data;
    logic          a_valid;
    logic          a_ready;
    logic [DW-1:0] b_data;
    logic          b_valid;
    logic          b_ready;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          sel;
`ifdef RR_MUX2_FEEDER_STATS_EN
    logic [7:0]    cnt_a;
    logic [7:0]    cnt_b;
`endif

    rr_mux2_feeder #(.DW(DW), .FIRST_B(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_data    (a_data),
        .a_valid   (a_valid),
        .a_ready   (a_ready),
        .b_data    (b_data),
        .b_valid   (b_valid),
        .b_ready   (b_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
`ifdef RR_MUX2_FEEDER_STATS_EN
        .cnt_a     (cnt_a),
        .cnt_b     (cnt_b),
`endif
        .sel       (sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_tests = 0;
    int            n_fail  = 0;
    logic [DW:0]   sb[$];
    logic [DW-1:0] na;
    logic [DW-1:0] nb;
    int            acc_a_n;
    int            acc_b_n;

    typedef struct {
        logic          av;
        logic [DW-1:0] ad;
        logic          bv;
        logic [DW-1:0] bd;
        logic          ordy;
        logic          e_ar;
        logic          e_br;
        logic          e_ov;
        logic          e_sel;
        logic [DW-1:0] e_od;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        a_valid   = 1'b0;
        b_valid   = 1'b0;
        a_data    = '0;
        b_data    = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst     = 1'b0;
        na      = '0;
        nb      = '0;
        acc_a_n = 0;
        acc_b_n = 0;
    endtask

    // Drives one cycle; every accepted word is queued in acceptance order (A before B)
    task automatic cycle_drive(input logic av, input logic bv, input logic ordy);
        logic acc_a;
        logic acc_b;
        out_ready = ordy;
        a_valid   = av;
        b_valid   = bv;
        a_data    = na;
        b_data    = nb;
        acc_a     = av && a_ready;
        acc_b     = bv && b_ready;
        if (acc_a) sb.push_back({1'b0, na});
        if (acc_b) sb.push_back({1'b1, nb});
        step();
        if (acc_a) begin
            na = na + 1'b1;
            acc_a_n++;
        end
        if (acc_b) begin
            nb = nb + 1'b1;
            acc_b_n++;
        end
    endtask

    task automatic apply_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            a_valid   = vecs[i].av;
            a_data    = vecs[i].ad;
            b_valid   = vecs[i].bv;
            b_data    = vecs[i].bd;
            out_ready = vecs[i].ordy;
            #1;
            check($sformatf("vec%0d_a_ready", i), a_ready, vecs[i].e_ar);
            check($sformatf("vec%0d_b_ready", i), b_ready, vecs[i].e_br);
            check($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].e_ov);
            if (vecs[i].e_ov) begin
                check($sformatf("vec%0d_sel", i), sel, vecs[i].e_sel);
                check($sformatf("vec%0d_out_data", i), out_data, vecs[i].e_od);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_a_ready"}, a_ready, 1);
        check({tag, "_b_ready"}, b_ready, 1);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_sel"}, sel, 0);
        check({tag, "_out_data"}, out_data, 0);
    endtask

    // Delivery monitor, sampled mid-cycle so the transfer is decided before the next edge
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out: got sel=%0d data=%0h with nothing expected", sel, out_data);
            end else begin
                check("out_word", {sel, out_data}, sb.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lows;
        //           av    ad     bv    bd     ordy  ar    br    ov    sel   od
        vecs[0]  = '{1'b1, 2'b10, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[1]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10};
        vecs[3]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[4]  = '{1'b1, 2'b01, 1'b1, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[5]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[6]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01};
        vecs[7]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11};
        vecs[8]  = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[9]  = '{1'b1, 2'b10, 1'b1, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00};
        vecs[10] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00};
        vecs[11] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b10};
        vecs[12] = '{1'b0, 2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00};

        // Single word, then ties showing the priority pointer returns to A
        do_reset();
        check_reset_state("reset");
        sb.push_back({1'b0, 2'b10});
        apply_rows(0, 3);
        do_reset();
        sb.push_back({1'b0, 2'b01});
        sb.push_back({1'b1, 2'b11});
        sb.push_back({1'b0, 2'b10});
        sb.push_back({1'b1, 2'b00});
        apply_rows(4, 12);

        // Continuous streaming on both channels
        do_reset();
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            if (i >= 2 && !out_valid) lows++;
            cycle_drive(1'b1, 1'b1, 1'b1);
        end
        check("stream_out_valid_gaps", lows, 0);
        check("stream_accepted_a", acc_a_n, 10);
        check("stream_accepted_b", acc_b_n, 10);
        repeat (6) cycle_drive(1'b0, 1'b0, 1'b1);

        // Backpressure for five cycles, then drain
        do_reset();
        na = 2'b01;
        nb = 2'b10;
        for (int i = 0; i < 5; i++) begin
            if (i >= 3) begin
                check($sformatf("bp%0d_a_ready", i), a_ready, 0);
                check($sformatf("bp%0d_b_ready", i), b_ready, 0);
                check($sformatf("bp%0d_out_valid", i), out_valid, 1);
                check($sformatf("bp%0d_sel", i), sel, 0);
                check($sformatf("bp%0d_out_data", i), out_data, 2'b01);
            end
            cycle_drive(1'b1, 1'b1, 1'b0);
        end
        repeat (6) cycle_drive(1'b0, 1'b0, 1'b1);

        // Reset while serving B with both holding registers full
        do_reset();
        out_ready = 1'b0;
        a_valid = 1'b1; a_data = 2'b01;
        b_valid = 1'b1; b_data = 2'b10;
        sb.push_back({1'b0, 2'b01});
        step();
        a_valid = 1'b0; b_valid = 1'b0;
        step();
        a_valid = 1'b1; a_data = 2'b11; out_ready = 1'b1;
        step();
        check("mid_sel_servb", sel, 1);
        check("mid_out_valid", out_valid, 1);
        a_valid = 1'b0; out_ready = 1'b0;
        b_valid = 1'b1; b_data = 2'b00;
        step();
        b_valid = 1'b0;
        check("mid_a_ready_full", a_ready, 0);
        check("mid_b_ready_full", b_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_a_ready", a_ready, 1);
        check("mid_rst_b_ready", b_ready, 1);
        check("mid_rst_sel", sel, 0);
        out_ready = 1'b1;
        lows = 0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) lows++;
            step();
        end
        check("mid_rst_no_replay", lows, 0);

`ifdef RR_MUX2_FEEDER_STATS_EN
        do_reset();
        check("stats_reset_a", cnt_a, 0);
        check("stats_reset_b", cnt_b, 0);
        for (int i = 0; i < 1000 && acc_a_n < 300; i++) begin
            cycle_drive(1'b1, acc_b_n < 3, 1'b1);
        end
        check("stats_accepted_a", acc_a_n, 300);
        repeat (6) cycle_drive(1'b0, 1'b0, 1'b1);
        check("stats_cnt_a", cnt_a, 255);
        check("stats_cnt_b", cnt_b, 3);
`endif

        check("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
